// File: rtl/btb_pkg.sv
// ============================================================================
// Module      : btb_pkg
// Description : Shared encodings for the branch target buffer predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btb_pkg;

    localparam logic [1:0] BTB_MODE_NT   = 2'd0;
    localparam logic [1:0] BTB_MODE_BTB  = 2'd1;
    localparam logic [1:0] BTB_MODE_SAT  = 2'd2;
    localparam logic [1:0] BTB_MODE_HYST = 2'd3;

    typedef enum logic [1:0] {
        CTR_SN = 2'b00,
        CTR_WN = 2'b01,
        CTR_WT = 2'b10,
        CTR_ST = 2'b11
    } ctr_t;

    localparam ctr_t CTR_INIT_RESET = CTR_WN;
    localparam ctr_t CTR_INIT_JUMP  = CTR_ST;
    localparam ctr_t CTR_INIT_ALLOC = CTR_WT;

endpackage

`default_nettype wire

// File: rtl/btb_ctr_next.sv
// ============================================================================
// Module      : btb_ctr_next
// Description : 2-bit direction counter transition (saturating / hysteresis).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_ctr_next
    import btb_pkg::*;
(
    input  logic [1:0] mode_i,
    input  ctr_t       ctr_i,
    input  logic       taken_i,
    output ctr_t       ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (mode_i == BTB_MODE_HYST) begin
            // Hysteresis: a weak state always jumps to the strong end of the outcome.
            if (taken_i) begin
                ctr_o = (ctr_i == CTR_SN) ? CTR_WN : CTR_ST;
            end else begin
                ctr_o = (ctr_i == CTR_ST) ? CTR_WT : CTR_SN;
            end
        end else begin
            if (taken_i) begin
                if (ctr_i != CTR_ST) ctr_o = ctr_t'(ctr_i + 2'd1);
            end else begin
                if (ctr_i != CTR_SN) ctr_o = ctr_t'(ctr_i - 2'd1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/btb_predictor.sv
// ============================================================================
// Module      : btb_predictor
// Description : Direct-mapped BTB with configurable direction prediction,
//               misprediction detection and saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_predictor
    import btb_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int ENTRIES   = 16,
    parameter int MODE      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic                 pred_taken,
    output logic [WORD_SIZE-1:0] pred_pc_next,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic                 upd_is_jump,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_pred_taken,
    input  logic [WORD_SIZE-1:0] upd_pred_target,
    output logic                 mispredict,
    output logic [WORD_SIZE-1:0] correct_pc,
    output logic [WORD_SIZE-1:0] branch_count,
    output logic [WORD_SIZE-1:0] mispredict_count
);

    localparam int         IDX    = $clog2(ENTRIES);
    localparam int         TAG_W  = WORD_SIZE - IDX;
    localparam logic [1:0] MODE_L = MODE[1:0];

    logic [ENTRIES-1:0]   valid_q;
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];
    ctr_t                 ctr_q    [ENTRIES];
    logic [WORD_SIZE-1:0] bcnt_q, bcnt_d;
    logic [WORD_SIZE-1:0] mcnt_q, mcnt_d;

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    assign lk_idx = if_pc[IDX-1:0];
    assign lk_tag = if_pc[WORD_SIZE-1:IDX];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    always_comb begin
        pred_taken = 1'b0;
        case (MODE_L)
            BTB_MODE_NT:  pred_taken = 1'b0;
            BTB_MODE_BTB: pred_taken = lk_hit;
            default:      pred_taken = lk_hit && ctr_q[lk_idx][1];
        endcase
    end

    assign pred_pc_next = pred_taken ? target_q[lk_idx] : if_pc + WORD_SIZE'(1);

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));
    assign correct_pc = !upd_valid ? '0 :
                        (upd_taken ? upd_target : upd_pc + WORD_SIZE'(1));

    logic [IDX-1:0]   up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    ctr_t             up_ctr_nxt;
    logic             wr_en_d;
    logic             wr_tgt_d;
    ctr_t             wr_ctr_d;

    assign up_idx = upd_pc[IDX-1:0];
    assign up_tag = upd_pc[WORD_SIZE-1:IDX];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    btb_ctr_next u_ctr_next (
        .mode_i  (MODE_L),
        .ctr_i   (ctr_q[up_idx]),
        .taken_i (upd_taken),
        .ctr_o   (up_ctr_nxt)
    );

    // Jumps and taken misses (re)allocate the slot; not-taken misses leave it alone.
    always_comb begin
        wr_en_d  = 1'b0;
        wr_tgt_d = 1'b0;
        wr_ctr_d = up_ctr_nxt;
        if (upd_valid) begin
            if (upd_is_jump) begin
                wr_en_d  = 1'b1;
                wr_tgt_d = 1'b1;
                wr_ctr_d = CTR_INIT_JUMP;
            end else if (up_hit) begin
                wr_en_d  = 1'b1;
                wr_tgt_d = upd_taken;
            end else if (upd_taken) begin
                wr_en_d  = 1'b1;
                wr_tgt_d = 1'b1;
                wr_ctr_d = CTR_INIT_ALLOC;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT_RESET;
            end
        end else if (wr_en_d) begin
            valid_q[up_idx] <= 1'b1;
            tag_q[up_idx]   <= up_tag;
            ctr_q[up_idx]   <= wr_ctr_d;
            if (wr_tgt_d) target_q[up_idx] <= upd_target;
        end
    end

    assign bcnt_d = (upd_valid && (bcnt_q != '1)) ? bcnt_q + WORD_SIZE'(1) : bcnt_q;
    assign mcnt_d = (mispredict && (mcnt_q != '1)) ? mcnt_q + WORD_SIZE'(1) : mcnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign branch_count     = bcnt_q;
    assign mispredict_count = mcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_btb_predictor.sv
// ============================================================================
// Module      : tb_btb_predictor
// Description : Self-checking bench; MODE 2 and MODE 3 instances share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] if_pc;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_pred_taken;
    logic [15:0] upd_pred_target;

    logic        s_pt, h_pt, s_mp, h_mp;
    logic [15:0] s_pn, h_pn, s_cpc, h_cpc, s_bc, h_bc, s_mc, h_mc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    btb_predictor #(.WORD_SIZE(16), .ENTRIES(16), .MODE(2)) u_sat (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(s_pt), .pred_pc_next(s_pn),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(s_mp), .correct_pc(s_cpc),
        .branch_count(s_bc), .mispredict_count(s_mc)
    );

    btb_predictor #(.WORD_SIZE(16), .ENTRIES(16), .MODE(3)) u_hyst (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(h_pt), .pred_pc_next(h_pn),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(h_mp), .correct_pc(h_cpc),
        .branch_count(h_bc), .mispredict_count(h_mc)
    );

    typedef struct {
        logic [15:0] if_pc;
        logic        uv;
        logic [15:0] upc;
        logic        jmp;
        logic        tk;
        logic [15:0] tgt;
        logic        ptk;
        logic [15:0] ptgt;
        logic        s_pt;
        logic [15:0] s_pn;
        logic        h_pt;
        logic [15:0] h_pn;
        logic        mp;
        logic [15:0] cpc;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] ipc, input logic uv, input logic [15:0] upc,
                         input logic jmp, input logic tk, input logic [15:0] tgt,
                         input logic ptk, input logic [15:0] ptgt);
        if_pc = ipc; upd_valid = uv; upd_pc = upc; upd_is_jump = jmp;
        upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
    endtask

    initial begin
        // Each row is one cycle: lookup expectations reflect table state before that edge.
        vecs[0]  = '{16'h0010,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b0,16'h0011,1'b0,16'h0011, 1'b0,16'h0000};
        vecs[1]  = '{16'h0010,1'b1,16'h0010,1'b0,1'b1,16'h0040,1'b0,16'h0011, 1'b0,16'h0011,1'b0,16'h0011, 1'b1,16'h0040};
        vecs[2]  = '{16'h0010,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b1,16'h0040,1'b1,16'h0040, 1'b0,16'h0000};
        vecs[3]  = '{16'h0010,1'b1,16'h0010,1'b0,1'b1,16'h0040,1'b1,16'h0040, 1'b1,16'h0040,1'b1,16'h0040, 1'b0,16'h0040};
        vecs[4]  = '{16'h0010,1'b1,16'h0010,1'b0,1'b1,16'h0040,1'b1,16'h0040, 1'b1,16'h0040,1'b1,16'h0040, 1'b0,16'h0040};
        vecs[5]  = '{16'h0010,1'b1,16'h0010,1'b0,1'b0,16'h0040,1'b1,16'h0040, 1'b1,16'h0040,1'b1,16'h0040, 1'b1,16'h0011};
        vecs[6]  = '{16'h0010,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b1,16'h0040,1'b1,16'h0040, 1'b0,16'h0000};
        vecs[7]  = '{16'h0010,1'b1,16'h0010,1'b0,1'b0,16'h0040,1'b1,16'h0040, 1'b1,16'h0040,1'b1,16'h0040, 1'b1,16'h0011};
        vecs[8]  = '{16'h0010,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b0,16'h0011,1'b0,16'h0011, 1'b0,16'h0000};
        vecs[9]  = '{16'h0010,1'b1,16'h0010,1'b0,1'b1,16'h0040,1'b0,16'h0011, 1'b0,16'h0011,1'b0,16'h0011, 1'b1,16'h0040};
        vecs[10] = '{16'h0010,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b1,16'h0040,1'b0,16'h0011, 1'b0,16'h0000};
        vecs[11] = '{16'h0010,1'b1,16'h0010,1'b0,1'b1,16'h0050,1'b1,16'h0040, 1'b1,16'h0040,1'b0,16'h0011, 1'b1,16'h0050};
        vecs[12] = '{16'h0010,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b1,16'h0050,1'b1,16'h0050, 1'b0,16'h0000};
        vecs[13] = '{16'h0005,1'b1,16'h0005,1'b1,1'b1,16'h0100,1'b0,16'h0006, 1'b0,16'h0006,1'b0,16'h0006, 1'b1,16'h0100};
        vecs[14] = '{16'h0005,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b1,16'h0100,1'b1,16'h0100, 1'b0,16'h0000};
        vecs[15] = '{16'h0015,1'b1,16'h0015,1'b0,1'b1,16'h0200,1'b0,16'h0016, 1'b0,16'h0016,1'b0,16'h0016, 1'b1,16'h0200};
        vecs[16] = '{16'h0005,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b0,16'h0006,1'b0,16'h0006, 1'b0,16'h0000};
        vecs[17] = '{16'h0015,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b1,16'h0200,1'b1,16'h0200, 1'b0,16'h0000};
        vecs[18] = '{16'h0007,1'b1,16'h0007,1'b0,1'b0,16'h0000,1'b0,16'h0008, 1'b0,16'h0008,1'b0,16'h0008, 1'b0,16'h0008};
        vecs[19] = '{16'h0007,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b0,16'h0008,1'b0,16'h0008, 1'b0,16'h0000};
        vecs[20] = '{16'hFFFF,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000, 1'b0,16'h0000};
        vecs[21] = '{16'hFFFF,1'b1,16'hFFFF,1'b1,1'b1,16'h0003,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000, 1'b1,16'h0003};
        vecs[22] = '{16'hFFFF,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b1,16'h0003,1'b1,16'h0003, 1'b0,16'h0000};
        vecs[23] = '{16'h0010,1'b0,16'h0010,1'b0,1'b1,16'h1234,1'b0,16'h0000, 1'b1,16'h0050,1'b1,16'h0050, 1'b0,16'h0000};
        vecs[24] = '{16'h0030,1'b1,16'h0030,1'b0,1'b0,16'h0099,1'b0,16'h0031, 1'b0,16'h0031,1'b0,16'h0031, 1'b0,16'h0031};
        vecs[25] = '{16'h0010,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b1,16'h0050,1'b1,16'h0050, 1'b0,16'h0000};

        reset = 1'b1;
        drive(16'h0010, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_pt", 0, 16'(s_pt), 16'h0);
        chk("rst_s_pn", 0, s_pn, 16'h0011);
        chk("rst_s_bc", 0, s_bc, 16'h0);
        chk("rst_s_mc", 0, s_mc, 16'h0);
        chk("rst_h_bc", 0, h_bc, 16'h0);
        chk("rst_h_mc", 0, h_mc, 16'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].if_pc, vecs[i].uv, vecs[i].upc, vecs[i].jmp,
                  vecs[i].tk, vecs[i].tgt, vecs[i].ptk, vecs[i].ptgt);
            #2;
            chk("sat_pred_taken",  i, 16'(s_pt),  16'(vecs[i].s_pt));
            chk("sat_pred_pc",     i, s_pn,       vecs[i].s_pn);
            chk("hyst_pred_taken", i, 16'(h_pt),  16'(vecs[i].h_pt));
            chk("hyst_pred_pc",    i, h_pn,       vecs[i].h_pn);
            chk("sat_mispredict",  i, 16'(s_mp),  16'(vecs[i].mp));
            chk("sat_correct_pc",  i, s_cpc,      vecs[i].cpc);
            chk("hyst_mispredict", i, 16'(h_mp),  16'(vecs[i].mp));
            chk("hyst_correct_pc", i, h_cpc,      vecs[i].cpc);
        end

        @(negedge clk);
        drive(16'h0010, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        #1;
        chk("sat_branch_cnt",  0, s_bc, 16'd12);
        chk("sat_mispred_cnt", 0, s_mc, 16'd8);
        chk("hyst_branch_cnt", 0, h_bc, 16'd12);
        chk("hyst_mispred_cnt",0, h_mc, 16'd8);

        // Asynchronous reset mid-training, with an update presented during reset.
        drive(16'h0010, 1'b1, 16'h0010, 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0011);
        reset = 1'b1;
        #1;
        chk("async_rst_pt",  0, 16'(s_pt), 16'h0);
        chk("async_rst_pn",  0, s_pn, 16'h0011);
        chk("async_rst_bc",  0, s_bc, 16'h0);
        chk("async_rst_hmc", 0, h_mc, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(16'h0010, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        #1;
        chk("post_rst_s_pt", 0, 16'(s_pt), 16'h0);
        chk("post_rst_h_pn", 0, h_pn, 16'h0011);
        chk("post_rst_bc",   0, s_bc, 16'h0);

        // Saturation: 0xFFFF+3 correctly-predicted not-taken branches.
        for (int n = 1; n <= 65538; n++) begin
            @(negedge clk);
            drive(16'h0010, 1'b1, 16'h0007, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0008);
            @(posedge clk);
            #1;
            if (n == 65534) chk("bc_fffe", n, s_bc, 16'hFFFE);
            if (n == 65535) chk("bc_ffff", n, s_bc, 16'hFFFF);
        end
        @(negedge clk);
        drive(16'h0010, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        #1;
        chk("sat_bc_hold",  0, s_bc, 16'hFFFF);
        chk("hyst_bc_hold", 0, h_bc, 16'hFFFF);
        chk("sat_mc_zero",  0, s_mc, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/btb_predictor.md
# btb_predictor

Parametrised branch target buffer and direction predictor for the pipelined CPU. It predicts the fetch PC in IF by combinational lookup on `if_pc`. It trains from the resolved branch/jump in MEM, where the datapath already computes `bcond` and the next PC, and flags mispredictions so the hazard logic can flush. It replaces the fixed always-not-taken fetch with configurable depth, width and prediction mode, and adds saturating performance counters.

## Interface
- `WORD_SIZE`, 16, PC/instruction width.
- `ENTRIES`, 16, table depth; power of two, 2..256; `IDX = $clog2(ENTRIES)`.
- `MODE`, 2, 0 = always not-taken, 1 = taken on BTB hit, 2 = 2-bit saturating, 3 = 2-bit hysteresis.
- `clk  input  1  clock; all state updates on rising edge`
- `reset  input  1  asynchronous, active-high; clears all state`
- `if_pc  input  WORD_SIZE  PC being fetched`
- `pred_taken  output  1  prediction for if_pc`
- `pred_pc_next  output  WORD_SIZE  predicted next fetch PC`
- `upd_valid  input  1  resolved control-flow instruction present in MEM`
- `upd_pc  input  WORD_SIZE  PC of resolved instruction`
- `upd_is_jump  input  1  unconditional (JMP/JAL/JPR/JRL); 0 = conditional branch`
- `upd_taken  input  1  actual direction (1 for jumps)`
- `upd_target  input  WORD_SIZE  actual target`
- `upd_pred_taken  input  1  prediction carried down the pipeline with the instruction`
- `upd_pred_target  input  WORD_SIZE  predicted next PC carried down the pipeline`
- `mispredict  output  1  flush request`
- `correct_pc  output  WORD_SIZE  PC to redirect fetch to`
- `branch_count  output  WORD_SIZE  resolved updates; saturating`
- `mispredict_count  output  WORD_SIZE  mispredictions; saturating`

## Operation
- Entry fields: `valid`, `tag = pc[WORD_SIZE-1:IDX]`, `target`, 2-bit `ctr` (00 SN, 01 WN, 10 WT, 11 ST). Index is `pc[IDX-1:0]`.
- Lookup (combinational): `hit = valid[idx] && tag matches`.
  - `pred_taken` = 0 in MODE 0; `hit` in MODE 1; `hit && ctr[1]` in MODE 2/3.
  - `pred_pc_next = pred_taken ? target : if_pc + 1`, with wrap at 2^WORD_SIZE.
- Misprediction (combinational, gated by `upd_valid`): set when `upd_taken != upd_pred_taken`, or when `upd_taken && upd_target != upd_pred_target`.
  - `correct_pc = upd_taken ? upd_target : upd_pc + 1`.
  - Both outputs are 0 when `upd_valid` = 0.
- Training at the clock edge when `upd_valid`:
  - Jump: write the entry (valid, tag, target, `ctr` = 11) whether it hits or misses.
  - Conditional branch, hit: update `ctr`; if taken, also overwrite `target`.
  - Conditional branch, miss and taken: allocate with `ctr` = 10, replacing any prior occupant (direct-mapped).
  - Conditional branch, miss and not-taken: no write.
- Counter update, MODE 2: taken increments, not-taken decrements, saturating at 11/00.
- Counter update, MODE 3, taken: SN→WN, WN→ST, WT→ST, ST→ST.
- Counter update, MODE 3, not-taken: ST→WT, WT→SN, WN→SN, SN→SN.
- MODE 0/1: table is still trained (valid/tag/target) but `ctr` is ignored on lookup.
- Perf counters: `branch_count` +1 per `upd_valid`; `mispredict_count` +1 per `mispredict`. Both hold at all-ones.

## Timing
- Lookup and mispredict outputs: zero-latency combinational.
- Table write becomes visible to lookups on the cycle after the edge.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents; there is no bypass.
- Reset asserted:
  - all `valid` = 0, all `ctr` = 01, `target`/tag = 0;
  - both perf counters = 0;
  - outputs settle to `pred_taken` = 0, `pred_pc_next = if_pc + 1`.
- Reset asserted mid-operation discards all training immediately. `upd_valid` is ignored while reset is high.
- `upd_pc` aliasing `if_pc` on a different tag evicts the entry on allocation; later lookups of the old PC miss.

## Structure
- Shared package `btb_pkg`:
  - MODE encodings (`BTB_MODE_NT`, `BTB_MODE_BTB`, `BTB_MODE_SAT`, `BTB_MODE_HYST`);
  - counter state constants `CTR_SN/WN/WT/ST`;
  - counter init values for jump (ST) and branch allocate (WT).
- One combinational sub-module, `btb_ctr_next` (inputs: mode, ctr, taken; output: next ctr), holds both transition tables.
- Storage is register arrays (not memory macro), so lookup can be asynchronous read.

## Test plan
- Reset, then `if_pc` = 0x0010: `pred_taken` = 0, `pred_pc_next` = 0x0011; both counters = 0.
- MODE 2, ENTRIES 16: update BNE@0x0010 taken→0x0040 with `upd_pred_taken` = 0.
  - During update: `mispredict` = 1, `correct_pc` = 0x0040.
  - Next cycle, lookup 0x0010: `pred_taken` = 1, `pred_pc_next` = 0x0040.
- MODE 2, ctr saturation and hysteresis check:
  - Train 0x0010 taken ×3 (ST), then not-taken ×1: prediction stays taken.
  - Second not-taken: prediction becomes not-taken.
  - MODE 3, same sequence: first not-taken → WT (still taken); second → SN.
- Aliasing, ENTRIES 16: JMP@0x0005→0x0100 allocated, then taken branch @0x0015→0x0200 allocated.
  - Lookup 0x0005 misses (`pred_pc_next` = 0x0006).
  - Lookup 0x0015 predicts 0x0200.
- Boundary cases:
  - Lookup 0xFFFF with no hit: `pred_pc_next` = 0x0000.
  - Same-cycle update/lookup of 0x0010 returns old entry.
  - Reset pulse mid-training clears the hit.
- Perf counters: force `branch_count` near 0xFFFF via 0xFFFF+3 updates; it must hold at 0xFFFF and never wrap.
